// File: rtl/sw_pkg.sv
// sw_pkg: constants and types shared by the Smith-Waterman pass controller
// and the S/T/V/F buffer blocks.
//   PE_NUM    - PEs per systolic array; one phase lasts PE_NUM cycles
//   CNT_W     - width of the array count bus
//   SYM_W     - symbol width
//   SCORE_W   - unsigned score width
//   DRAIN_CYC - cycles after the last phase during which scores are collected
//   sw_state_t - pass controller state encoding
package sw_pkg;

  localparam int PE_NUM    = 128;
  localparam int CNT_W     = 12;
  localparam int SYM_W     = 2;
  localparam int SCORE_W   = 10;
  localparam int DRAIN_CYC = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_IN  = 3'd1,
    ST_RUN_BUF = 3'd2,
    ST_RUN_OUT = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } sw_state_t;

endpackage

// File: rtl/sw_max_tracker.sv
// sw_max_tracker: holds the running maximum of candidate scores for one pass.
// Optional build macro: SW_POS_TRACK_EN adds max_pos, the count value at
// which the current maximum was captured.
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   i_clr          clear maximum (and position) on an accepted start
//   i_en           tracking window is open (RUN and DRAIN states)
//   i_score_valid  i_score is a candidate this cycle
//   i_score        candidate score
//   i_count        current array count (used for position only)
//   o_max_score    running maximum
//   o_max_pos      count of the last update (SW_POS_TRACK_EN only)
module sw_max_tracker
  import sw_pkg::*;
#(
  parameter int SCORE_W = sw_pkg::SCORE_W,
  parameter int CNT_W   = sw_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_score_valid,
  input  logic [SCORE_W-1:0] i_score,
`ifdef SW_POS_TRACK_EN
  input  logic [CNT_W-1:0]   i_count,
  output logic [CNT_W-1:0]   o_max_pos,
`endif
  output logic [SCORE_W-1:0] o_max_score
);

  logic [SCORE_W-1:0] r_max;
  logic               w_update;

  // Strictly greater: a tie keeps the earlier maximum (and its position).
  assign w_update = i_en && i_score_valid && (i_score > r_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max <= '0;
    end else if (i_clr) begin
      r_max <= '0;
    end else if (w_update) begin
      r_max <= i_score;
    end
  end

  assign o_max_score = r_max;

`ifdef SW_POS_TRACK_EN
  logic [CNT_W-1:0] r_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos <= '0;
    end else if (i_clr) begin
      r_pos <= '0;
    end else if (w_update) begin
      r_pos <= i_count;
    end
  end

  assign o_max_pos = r_pos;
`endif

endmodule

// File: rtl/sw_pass_ctrl.sv
// sw_pass_ctrl: sequencer for one Smith-Waterman pass over the systolic array.
// Generates the array valid/count timeline, streams 2*PE_NUM S symbols into
// the buffer chain, tracks the best candidate score and pulses done.
// Optional build macro: SW_POS_TRACK_EN adds output max_pos.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start            begin a pass (sampled only in IDLE)
//   busy             high in every state except IDLE
//   s_valid/s_data   upstream S symbol source
//   s_ready          a symbol is consumed this cycle (RUN_IN, RUN_BUF)
//   arr_valid        array valid (RUN_IN, RUN_BUF, RUN_OUT)
//   arr_count        array count, 1 after start, +1 per cycle until IDLE
//   arr_data_s       symbol into the buffer chain (0 when not consumed)
//   pe_score_valid/pe_score  candidate score from the last column
//   done             one-cycle end-of-pass pulse
//   max_score        pass maximum, held until the next accepted start
//   err_underflow    sticky: symbol needed while s_valid was low
//   max_pos          count of the maximum (SW_POS_TRACK_EN only)
module sw_pass_ctrl
  import sw_pkg::*;
#(
  parameter int PE_NUM    = sw_pkg::PE_NUM,
  parameter int CNT_W     = sw_pkg::CNT_W,
  parameter int SYM_W     = sw_pkg::SYM_W,
  parameter int SCORE_W   = sw_pkg::SCORE_W,
  parameter int DRAIN_CYC = sw_pkg::DRAIN_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  input  logic               s_valid,
  input  logic [SYM_W-1:0]   s_data,
  output logic               s_ready,
  output logic               arr_valid,
  output logic [CNT_W-1:0]   arr_count,
  output logic [SYM_W-1:0]   arr_data_s,
  input  logic               pe_score_valid,
  input  logic [SCORE_W-1:0] pe_score,
`ifdef SW_POS_TRACK_EN
  output logic [CNT_W-1:0]   max_pos,
`endif
  output logic               done,
  output logic [SCORE_W-1:0] max_score,
  output logic               err_underflow
);

  // Last count value of each phase.
  localparam logic [CNT_W-1:0] L_IN_END    = CNT_W'(PE_NUM);
  localparam logic [CNT_W-1:0] L_BUF_END   = CNT_W'(2 * PE_NUM);
  localparam logic [CNT_W-1:0] L_OUT_END   = CNT_W'(3 * PE_NUM);
  localparam logic [CNT_W-1:0] L_DRAIN_END = CNT_W'(3 * PE_NUM + DRAIN_CYC);

  sw_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic             r_err;
  logic             w_start_acc;
  logic             w_track_en;

  assign w_start_acc = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count + 1'b1;
    busy         = 1'b1;
    arr_valid    = 1'b0;
    s_ready      = 1'b0;
    done         = 1'b0;
    w_track_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy         = 1'b0;
        w_count_next = '0;
        if (start) begin
          w_state_next = ST_RUN_IN;
          w_count_next = CNT_W'(1);
        end
      end
      ST_RUN_IN: begin
        arr_valid  = 1'b1;
        s_ready    = 1'b1;
        w_track_en = 1'b1;
        if (r_count == L_IN_END) w_state_next = ST_RUN_BUF;
      end
      ST_RUN_BUF: begin
        arr_valid  = 1'b1;
        s_ready    = 1'b1;
        w_track_en = 1'b1;
        if (r_count == L_BUF_END) w_state_next = ST_RUN_OUT;
      end
      ST_RUN_OUT: begin
        arr_valid  = 1'b1;
        w_track_en = 1'b1;
        if (r_count == L_OUT_END) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Tracking stays enabled on the exit cycle so a score arriving with
        // the last drain count is still compared.
        w_track_en = 1'b1;
        if (r_count == L_DRAIN_END) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
        w_count_next = '0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  assign arr_count  = r_count;
  assign arr_data_s = (s_ready && s_valid) ? s_data : '0;

  // The buffer chain shifts every cycle, so a missing symbol is replaced by
  // 0 and flagged rather than stalling the pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (s_ready && !s_valid) begin
      r_err <= 1'b1;
    end
  end

  assign err_underflow = r_err;

  sw_max_tracker #(
    .SCORE_W(SCORE_W),
    .CNT_W  (CNT_W)
  ) u_max_tracker (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start_acc),
    .i_en         (w_track_en),
    .i_score_valid(pe_score_valid),
    .i_score      (pe_score),
`ifdef SW_POS_TRACK_EN
    .i_count      (r_count),
    .o_max_pos    (max_pos),
`endif
    .o_max_score  (max_score)
  );

endmodule

// File: tb/tb_sw_pass_ctrl.sv
module tb_sw_pass_ctrl;
  import sw_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               s_valid = 1'b0;
  logic [SYM_W-1:0]   s_data = '0;
  logic               pe_score_valid = 1'b0;
  logic [SCORE_W-1:0] pe_score = '0;
  logic               busy, s_ready, arr_valid, done, err_underflow;
  logic [CNT_W-1:0]   arr_count;
  logic [SYM_W-1:0]   arr_data_s;
  logic [SCORE_W-1:0] max_score;
`ifdef SW_POS_TRACK_EN
  logic [CNT_W-1:0]   max_pos;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Per-pass statistics filled by run_pass
  int n_valid, n_ready, n_done, done_at, cnt_bad, data_bad;
  int first_cnt, first_valid, max_at_done, err_at_done, pos_at_done, data_at_uf;

  always #5 clk = ~clk;

  sw_pass_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .arr_valid     (arr_valid),
    .arr_count     (arr_count),
    .arr_data_s    (arr_data_s),
    .pe_score_valid(pe_score_valid),
    .pe_score      (pe_score),
`ifdef SW_POS_TRACK_EN
    .max_pos       (max_pos),
`endif
    .done          (done),
    .max_score     (max_score),
    .err_underflow (err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_score(input int v);
    pe_score_valid = 1'b1;
    pe_score       = SCORE_W'(v);
  endtask

  // Drive the inputs for the cycle whose arr_count is c.
  // mode 0: scores 5,9,9,3 at 10,200,300,450 plus ignored start pulses
  // mode 1: score 7 on the final drain count 512
  // mode 2: score 4 at 20, score 30 in the DONE cycle (must be ignored)
  // mode 3: score 11 at 100 (reset-abort pass)
  task automatic drive_inputs(input int mode, input int uf_at, input int c);
    s_valid        = (c != uf_at);
    s_data         = (c > 0) ? SYM_W'((c - 1) % 4) : '0;
    pe_score_valid = 1'b0;
    pe_score       = '0;
    start          = (mode == 0) && (c == 100 || c == 513);
    case (mode)
      0: begin
        if (c == 10)  set_score(5);
        if (c == 200) set_score(9);
        if (c == 300) set_score(9);
        if (c == 450) set_score(3);
      end
      1: if (c == 512) set_score(7);
      2: begin
        if (c == 20)  set_score(4);
        if (c == 513) set_score(30);
      end
      3: if (c == 100) set_score(11);
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    start = 1'b0; s_valid = 1'b0; s_data = '0;
    pe_score_valid = 1'b0; pe_score = '0;
  endtask

  task automatic run_pass(input int mode, input int uf_at);
    int c, exp_d;
    n_valid = 0; n_ready = 0; n_done = 0; done_at = -1; cnt_bad = 0; data_bad = 0;
    first_cnt = -1; first_valid = -1; max_at_done = -1; err_at_done = -1;
    pos_at_done = -1; data_at_uf = -1;
    start = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk); #1;
      c = int'(arr_count);
      if (n == 1) begin
        first_cnt   = c;
        first_valid = int'(arr_valid);
      end
      if (done_at < 0 && c != n) cnt_bad++;
      drive_inputs(mode, uf_at, c);
      #1;
      exp_d = (c >= 1 && c <= 256 && c != uf_at) ? ((c - 1) % 4) : 0;
      if (int'(arr_data_s) != exp_d) data_bad++;
      if (arr_valid) n_valid++;
      if (s_ready)   n_ready++;
      if (c == uf_at) data_at_uf = int'(arr_data_s);
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at     = n;
          max_at_done = int'(max_score);
          err_at_done = int'(err_underflow);
`ifdef SW_POS_TRACK_EN
          pos_at_done = int'(max_pos);
`endif
        end
      end
      if (done_at > 0 && n >= done_at + 20) break;
    end
    idle_inputs();
  endtask

  task automatic check_pass(input string p, input int exp_max, input int exp_err, input int exp_pos);
    check({p, "_first_count"}, first_cnt, 1);
    check({p, "_first_valid"}, first_valid, 1);
    check({p, "_count_seq"}, cnt_bad, 0);
    check({p, "_valid_cycles"}, n_valid, 384);
    check({p, "_ready_cycles"}, n_ready, 256);
    check({p, "_done_cycle"}, done_at, 513);
    check({p, "_done_pulses"}, n_done, 1);
    check({p, "_data_s"}, data_bad, 0);
    check({p, "_max_at_done"}, max_at_done, exp_max);
    check({p, "_err_at_done"}, err_at_done, exp_err);
`ifdef SW_POS_TRACK_EN
    check({p, "_pos_at_done"}, pos_at_done, exp_pos);
`else
    if (exp_pos < 0) check({p, "_pos_unused"}, pos_at_done, exp_pos);
`endif
    check({p, "_idle_busy"}, busy, 0);
    check({p, "_idle_count"}, arr_count, 0);
    check({p, "_max_held"}, max_score, exp_max);
  endtask

  initial begin
    int found, cnt_busy, cnt_done;

    // Reset state (s_valid high to show arr_data_s is gated)
    s_valid = 1'b1; s_data = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", s_ready, 0);
    check("rst_valid", arr_valid, 0);
    check("rst_count", arr_count, 0);
    check("rst_data", arr_data_s, 0);
    check("rst_done", done, 0);
    check("rst_max", max_score, 0);
    check("rst_err", err_underflow, 0);
`ifdef SW_POS_TRACK_EN
    check("rst_pos", max_pos, 0);
`endif
    rst = 1'b0;
    idle_inputs();

    // Idle without start
    cnt_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy || arr_count != 0 || arr_valid) cnt_busy++;
    end
    check("idle_quiet", cnt_busy, 0);
    $display("step idle: 20 cycles without start");

    // Pass A: clean, scores with tie, ignored start pulses
    run_pass(0, -1);
    check_pass("passA", 9, 0, 200);
    $display("step passA: done at %0d max %0d", done_at, max_at_done);

    // Pass B: underflow at count 50, score on final drain cycle
    run_pass(1, 50);
    check_pass("passB", 7, 1, 512);
    check("passB_uf_data", data_at_uf, 0);
    check("passB_err_held", err_underflow, 1);
    $display("step passB: done at %0d err %0d", done_at, err_at_done);

    // Pass C: reset at count 300
    start = 1'b1;
    found = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      drive_inputs(3, -1, int'(arr_count));
      if (arr_count == 300) begin
        found = 1;
        break;
      end
    end
    check("passC_reach_300", found, 1);
    check("passC_pre_rst_max", max_score, 11);
    rst = 1'b1;
    @(posedge clk); #1;
    check("passC_rst_busy", busy, 0);
    check("passC_rst_count", arr_count, 0);
    check("passC_rst_valid", arr_valid, 0);
    check("passC_rst_ready", s_ready, 0);
    check("passC_rst_max", max_score, 0);
    rst = 1'b0;
    idle_inputs();
    cnt_done = 0; cnt_busy = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("passC_no_done", cnt_done, 0);
    check("passC_stays_idle", cnt_busy, 0);
    $display("step passC: reset at count 300, done pulses %0d", cnt_done);

    // Pass D: clean pass after reset; DONE-cycle score ignored
    run_pass(2, -1);
    check_pass("passD", 4, 0, 20);
    $display("step passD: done at %0d max %0d", done_at, max_at_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
